// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: immediate / load-data extender followed by a DEPTH-entry
// result FIFO. Each accepted request is extended combinationally, stored
// together with its error bit, and presented at the FIFO head one cycle later.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high and flush is low. in_ready depends only on occupancy and reset_n and
// never on out_ready, so a full FIFO refuses a push even if it pops in the same
// cycle. out_valid stays high, and out_data/out_err stay stable, until the
// consumer raises out_ready.
module ext_pipe_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int SA_W   = 5,
  parameter int DEPTH  = 2,
  localparam int OFF_W = $clog2(DATA_W / 8),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [SA_W-1:0]   sa,
  input  logic [DATA_W-1:0] mem_word,
  input  logic [OFF_W-1:0]  byte_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [3:0] M_ZERO = 4'd0;
  localparam logic [3:0] M_ZIMM = 4'd1;
  localparam logic [3:0] M_SIMM = 4'd2;
  localparam logic [3:0] M_HIMM = 4'd3;
  localparam logic [3:0] M_SA   = 4'd4;
  localparam logic [3:0] M_LB   = 4'd5;
  localparam logic [3:0] M_LBU  = 4'd6;
  localparam logic [3:0] M_LH   = 4'd7;
  localparam logic [3:0] M_LHU  = 4'd8;
  localparam logic [3:0] M_LW   = 4'd9;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  err_mem;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  logic [DATA_W-1:0] byte_sh;
  logic [DATA_W-1:0] half_sh;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;
  logic              push;
  logic              pop;

  // Extend the incoming request; the selected lane is shifted down to bit 0.
  always_comb begin
    byte_sh  = mem_word >> (32'(byte_off) * 32'd8);
    half_sh  = mem_word >> ((32'(byte_off) >> 1) * 32'd16);
    ext_data = '0;
    ext_err  = 1'b0;
    case (mode)
      M_ZERO: ext_data = '0;
      M_ZIMM: ext_data = DATA_W'(imm);
      M_SIMM: ext_data = DATA_W'($signed(imm));
      M_HIMM: ext_data = DATA_W'(imm) << (DATA_W - IMM_W);
      M_SA:   ext_data = DATA_W'(sa);
      M_LB:   ext_data = DATA_W'($signed(byte_sh[7:0]));
      M_LBU:  ext_data = DATA_W'(byte_sh[7:0]);
      M_LH, M_LHU: begin
        if (byte_off[0]) begin
          ext_err = 1'b1;
        end else if (mode == M_LH) begin
          ext_data = DATA_W'($signed(half_sh[15:0]));
        end else begin
          ext_data = DATA_W'(half_sh[15:0]);
        end
      end
      M_LW: begin
        if (byte_off != '0) ext_err = 1'b1;
        else                ext_data = mem_word;
      end
      default: ext_err = 1'b1;
    endcase
  end

  // Handshake qualifiers and head presentation (zero when empty).
  always_comb begin
    in_ready  = reset_n & (count < CNT_W'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    out_data  = out_valid ? data_mem[rptr] : '0;
    out_err   = out_valid ? err_mem[rptr] : 1'b0;
  end

  // Storage array: written only on an accepted push, no reset needed since
  // the head is masked by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr] <= ext_data;
      err_mem[wptr]  <= ext_err;
    end
  end

  // Pointers and occupancy; reset wins over flush, both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Bench for ext_pipe_unit: a queue-based model of the FIFO plus a spec-level
// extension function, checked every cycle, and directed literal checks.
module tb_ext_pipe_unit;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int SA_W   = 5;
  localparam int DEPTH  = 2;
  localparam int OFF_W  = 2;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        mode;
  logic [IMM_W-1:0]  imm;
  logic [SA_W-1:0]   sa;
  logic [DATA_W-1:0] mem_word;
  logic [OFF_W-1:0]  byte_off;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [CNT_W-1:0]  count;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W:0] exp_q[$];  // {err, data}
  logic [DATA_W:0] m_e;
  bit              m_push;
  bit              m_pop;
  bit              live = 0;

  ext_pipe_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SA_W(SA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .imm(imm), .sa(sa), .mem_word(mem_word), .byte_off(byte_off),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .count(count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {err, data} straight from the mode table, plain arithmetic.
  function automatic logic [DATA_W:0] model_ext(input logic [3:0] m, input logic [15:0] im,
                                                input logic [4:0] s, input logic [31:0] w,
                                                input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (m)
      4'd0: return {1'b0, 32'h0};
      4'd1: return {1'b0, 32'(im)};
      4'd2: return {1'b0, (im >= 16'h8000) ? (32'hFFFF0000 | 32'(im)) : 32'(im)};
      4'd3: return {1'b0, 32'(im) * 32'h10000};
      4'd4: return {1'b0, 32'(s)};
      4'd5: return {1'b0, (b >= 128) ? (b | 32'hFFFFFF00) : b};
      4'd6: return {1'b0, b};
      4'd7: return (off % 2 != 0) ? {1'b1, 32'h0}
                                  : {1'b0, (h >= 32768) ? (h | 32'hFFFF0000) : h};
      4'd8: return (off % 2 != 0) ? {1'b1, 32'h0} : {1'b0, h};
      4'd9: return (off != 0) ? {1'b1, 32'h0} : {1'b0, w};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every rising edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      live = 1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_push = in_valid && (exp_q.size() < DEPTH);
      m_pop  = (exp_q.size() != 0) && out_ready;
      m_e    = model_ext(mode, imm, sa, mem_word, byte_off);
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_e);
    end
  end

  // Compare process: all outputs checked against the model on every falling edge.
  always @(negedge clk) begin
    if (live) begin
      check("m_in_ready", 64'(in_ready), 64'(reset_n && (exp_q.size() < DEPTH)));
      check("m_count", 64'(count), 64'(exp_q.size()));
      check("m_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("m_out_data", 64'(out_data), 64'(exp_q[0][DATA_W-1:0]));
        check("m_out_err", 64'(out_err), 64'(exp_q[0][DATA_W]));
      end else begin
        check("m_out_data_empty", 64'(out_data), 64'h0);
        check("m_out_err_empty", 64'(out_err), 64'h0);
      end
    end
  end

  // Driver tasks; all driving happens right after a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] m, input logic [15:0] im, input logic [4:0] s,
                       input logic [31:0] w, input logic [1:0] off);
    mode = m; imm = im; sa = s; mem_word = w; byte_off = off;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] m, input logic [15:0] im, input logic [4:0] s,
                      input logic [31:0] w, input logic [1:0] off,
                      input logic [31:0] ed, input logic ee, input string name);
    out_ready = 1'b1;
    drive(m, im, s, w, off);
    step();
    in_valid = 1'b0;
    check({name, "_valid"}, 64'(out_valid), 64'h1);
    check({name, "_data"}, 64'(out_data), 64'(ed));
    check({name, "_err"}, 64'(out_err), 64'(ee));
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = '0; imm = '0; sa = '0; mem_word = '0; byte_off = '0;
    step();
    step();
    check("rst_count", 64'(count), 64'h0);
    check("rst_in_ready_low", 64'(in_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    reset_n = 1'b1;
    step();
    check("rst_in_ready_high", 64'(in_ready), 64'h1);

    // immediates
    send(4'd1, 16'h8001, 5'd31, 32'h0, 2'd0, 32'h00008001, 1'b0, "zimm");
    send(4'd2, 16'h8001, 5'd31, 32'h0, 2'd0, 32'hFFFF8001, 1'b0, "simm");
    send(4'd3, 16'h8001, 5'd31, 32'h0, 2'd0, 32'h80010000, 1'b0, "himm");
    send(4'd4, 16'h8001, 5'd31, 32'h0, 2'd0, 32'h0000001F, 1'b0, "sa");
    send(4'd0, 16'h8001, 5'd31, 32'h0, 2'd0, 32'h00000000, 1'b0, "zero");
    // loads
    send(4'd5, 16'h0, 5'd0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0, "lb1");
    send(4'd5, 16'h0, 5'd0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0, "lb2");
    send(4'd6, 16'h0, 5'd0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0, "lbu3");
    send(4'd7, 16'h0, 5'd0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0, "lh2");
    send(4'd8, 16'h0, 5'd0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0, "lhu0");
    send(4'd9, 16'h0, 5'd0, 32'h80FF7F01, 2'd0, 32'h80FF7F01, 1'b0, "lw0");
    // misaligned / illegal
    send(4'd7, 16'h0, 5'd0, 32'h80FF7F01, 2'd1, 32'h0, 1'b1, "lh_mis");
    send(4'd9, 16'h0, 5'd0, 32'h80FF7F01, 2'd2, 32'h0, 1'b1, "lw_mis");
    send(4'd12, 16'h1234, 5'd3, 32'h80FF7F01, 2'd0, 32'h0, 1'b1, "illegal");
    // back-to-back error requests: no stall
    drive(4'd7, 16'h0, 5'd0, 32'h12345678, 2'd3); step();
    check("stream_ready", 64'(in_ready), 64'h1);
    drive(4'd15, 16'h0, 5'd0, 32'h12345678, 2'd0); step();
    drive(4'd6, 16'h0, 5'd0, 32'h12345678, 2'd0); step();
    check("stream_lbu", 64'(out_data), 64'h78);
    in_valid = 1'b0;
    step(); step();

    // backpressure
    out_ready = 1'b0;
    drive(4'd1, 16'h00AA, 5'd0, 32'h0, 2'd0); step();
    drive(4'd1, 16'h00BB, 5'd0, 32'h0, 2'd0); step();
    check("bp_count_full", 64'(count), 64'h2);
    check("bp_ready_full", 64'(in_ready), 64'h0);
    drive(4'd1, 16'h00CC, 5'd0, 32'h0, 2'd0); step();
    check("bp_refused_count", 64'(count), 64'h2);
    check("bp_head_a", 64'(out_data), 64'hAA);
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("bp_ready_back", 64'(in_ready), 64'h1);
    check("bp_head_b", 64'(out_data), 64'hBB);
    step();
    check("bp_empty", 64'(out_valid), 64'h0);

    // full with simultaneous pop, then push+pop across pointer wrap
    out_ready = 1'b0;
    drive(4'd1, 16'h000D, 5'd0, 32'h0, 2'd0); step();
    drive(4'd1, 16'h000E, 5'd0, 32'h0, 2'd0); step();
    out_ready = 1'b1;
    drive(4'd1, 16'h000F, 5'd0, 32'h0, 2'd0); step();
    check("fp_pop_only_count", 64'(count), 64'h1);
    check("fp_head_e", 64'(out_data), 64'hE);
    step();
    check("fp_pushpop_count", 64'(count), 64'h1);
    check("fp_head_f", 64'(out_data), 64'hF);
    drive(4'd2, 16'hFFF0, 5'd0, 32'h0, 2'd0); step();
    check("fp_head_g", 64'(out_data), 64'hFFFFFFF0);
    in_valid = 1'b0; step();

    // flush with 2 entries buffered and a concurrent input
    out_ready = 1'b0;
    drive(4'd1, 16'h0011, 5'd0, 32'h0, 2'd0); step();
    drive(4'd1, 16'h0022, 5'd0, 32'h0, 2'd0); step();
    flush = 1'b1;
    drive(4'd1, 16'h0033, 5'd0, 32'h0, 2'd0); step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 64'(count), 64'h0);
    check("fl_valid", 64'(out_valid), 64'h0);
    check("fl_ready", 64'(in_ready), 64'h1);
    step();
    check("fl_lost", 64'(out_valid), 64'h0);

    // reset mid-stream
    drive(4'd1, 16'h0044, 5'd0, 32'h0, 2'd0); step();
    drive(4'd1, 16'h0055, 5'd0, 32'h0, 2'd0); step();
    reset_n = 1'b0;
    drive(4'd1, 16'h0066, 5'd0, 32'h0, 2'd0); step();
    check("mr_ready", 64'(in_ready), 64'h0);
    check("mr_count", 64'(count), 64'h0);
    check("mr_data", 64'(out_data), 64'h0);
    check("mr_err", 64'(out_err), 64'h0);
    flush = 1'b1; step();
    check("mr_flush_count", 64'(count), 64'h0);
    flush = 1'b0; in_valid = 1'b0; reset_n = 1'b1;
    #1;
    check("mr_ready_after", 64'(in_ready), 64'h1);
    step();

    // random traffic, checked by the model
    for (int i = 0; i < 80; i++) begin
      mode      = 4'($urandom_range(0, 15));
      imm       = 16'($urandom);
      sa        = 5'($urandom_range(0, 31));
      mem_word  = $urandom;
      byte_off  = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ext_pipe_unit.md
Name: ext_pipe_unit

Overview:
- Parametrised, buffered successor to the single-cycle immediate extender.
- Handles immediate extension and load-data extension (lb/lbu/lh/lhu/lw byte-lane select plus sign/zero extension).
- Results pass through a DEPTH-entry FIFO with valid/ready handshakes on both sides, a flush input and a misalignment error flag.
- Sits between the MEM/WB boundary and writeback, and is reusable for the ID-stage immediate path.

Parameters:
- DATA_W, 32: output and memory word width; multiple of 8, at least 16.
- IMM_W, 16: immediate field width; less than DATA_W.
- SA_W, 5: shift-amount field width; less than DATA_W.
- DEPTH, 2: FIFO entries; power of 2, at least 2.
- OFF_W (derived): $clog2(DATA_W/8), byte-offset width.
- CNT_W (derived): $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  discards all buffered entries and the current input.
- in_valid  in  1  an input request is present.
- in_ready  out  1  unit can accept a request.
- mode  in  4  operation select (codes below).
- imm  in  IMM_W  immediate field.
- sa  in  SA_W  shift-amount field.
- mem_word  in  DATA_W  word read from data memory.
- byte_off  in  OFF_W  address low bits.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_W  extended result at the head.
- out_err  out  1  head request was misaligned or used an illegal mode.
- count  out  CNT_W  current occupancy.

Behaviour:
- The clock is clk. Reset is synchronous, active-low: reset_n sampled low at a rising edge of clk resets the unit. Only one clock is used.
- Reset values:
  - count=0, out_valid=0, out_data=0, out_err=0.
  - FIFO pointers are 0.
  - in_ready=0 while reset_n is low, 1 afterwards.
- Mode codes (result computed combinationally at input, then stored with its err bit). Lane L = byte_off for byte ops, byte_off>>1 for halfword ops; little-endian lanes.
  - 0: result 0.
  - 1: zero-extend imm.
  - 2: sign-extend imm.
  - 3: imm placed in the top IMM_W bits, low bits 0.
  - 4: zero-extend sa.
  - 5 (lb): sign-extend mem_word byte lane L.
  - 6 (lbu): zero-extend mem_word byte lane L.
  - 7 (lh): sign-extend mem_word halfword lane L; err=1 and result 0 if byte_off[0]=1.
  - 8 (lhu): as 7 but zero-extended.
  - 9 (lw): result = mem_word; err=1 and result 0 if byte_off is not 0.
  - 10–15: result 0, err=1.
- Handshake:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - in_ready = (count < DEPTH). There is no combinational ready path from out_ready. When full, a push is refused even if a pop happens in the same cycle.
- Latency: an entry pushed at edge k drives out_valid=1 with its data from just after edge k (1-cycle latency).
- Occupancy:
  - out_valid = (count != 0).
  - out_data and out_err come from the head register. They are held stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - count never exceeds DEPTH and never underflows.
- Flush:
  - At the edge: count goes to 0, pointers go to 0, out_valid=0, and the concurrent input is dropped.
  - in_ready=1 the following cycle.
  - Flush together with reset_n=0: reset wins. Both give the same result.
- When count=0, out_data and out_err are 0.
- Reset mid-operation: all entries are lost and there is no partial output.
- Input fields are ignored when push=0.

Test Plan:
- Immediate modes, imm=16'h8001, sa=5'd31, out_ready=1 → modes 1/2/3/4 give 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'h0000001F one cycle after push, err=0.
- Loads, mem_word=32'h80FF7F01:
  - lb off=1 → 32'h0000007F
  - lb off=2 → 32'hFFFFFFFF
  - lbu off=3 → 32'h00000080
  - lh off=2 → 32'hFFFF80FF
  - lhu off=0 → 32'h00007F01
  - lw off=0 → 32'h80FF7F01
- Misaligned/illegal: lh off=1, lw off=2, mode=12 → out_data=0, out_err=1 for each. Pipeline continues with no stall.
- Backpressure, DEPTH=2: out_ready=0, push A then B → count=2, in_ready=0, third request refused. Raise out_ready → A then B popped in order, in_ready returns to 1 after the first pop edge.
- Full with simultaneous pop: count=2, out_ready=1, in_valid=1 → pop only, count=1. Next cycle push and pop together → count stays 1, with correct order across pointer wrap.
- Flush and reset: with 2 entries buffered, flush=1 plus in_valid=1 → count=0, out_valid=0 next cycle, input lost. Repeat with reset_n=0 mid-stream → all outputs at reset values, in_ready=0 during reset, 1 after.
